diff_integrator: RTL

Reconstructs signed ECG samples from a stream of signed first differences: y[n] = sat(y[n-1] + d[n]). It is the decode side of the pipelined subtracter that produces 9-bit differences from 8-bit samples, and it sits between the difference-domain datapath and any block that needs absolute samples. It has a two-stage registered pipeline with valid/ready handshakes on both sides, saturation with a sticky flag, and frame counting with an end-of-frame marker.

---
 rtl/diff_integrator.sv | 81 ++++++++
 1 files changed

// File: rtl/diff_integrator.sv
// diff_integrator: rebuilds saturated signed samples from first differences through a two-stage valid/ready pipeline.
module diff_integrator #(
  parameter int DW = 8,
  parameter int FRAME_LEN = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW:0]   in_delta,
  input  logic                 in_first,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_sample,
  output logic                 out_last,
  output logic                 sat_flag,
  input  logic                 sat_clr
);
  localparam logic signed [DW+1:0] MAXV = (DW+2)'((2 ** (DW-1)) - 1);
  localparam logic signed [DW+1:0] MINV = (DW+2)'(-(2 ** (DW-1)));
  logic                 s1_valid_q, s1_valid_d, s1_first_q, s1_first_d;
  logic signed [DW:0]   s1_delta_q, s1_delta_d;
  logic                 out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic signed [DW-1:0] out_sample_q, out_sample_d, acc_q, acc_d;
  logic [15:0]          fcnt_q, fcnt_d, fcnt_next;
  logic                 sat_q, sat_d;
  logic                 adv, load, take, clip_hi, clip_lo, hit_last;
  logic signed [DW+1:0] d_ext, a_ext, sum;
  logic signed [DW-1:0] clipped;
  assign adv        = !out_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || adv;
  assign take       = in_valid && in_ready;
  assign load       = s1_valid_q && adv;
  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign out_last   = out_last_q;
  assign sat_flag   = sat_q;
  // A seed beat bypasses the accumulator so it is clipped as an absolute value.
  always_comb begin
    d_ext      = (DW+2)'(s1_delta_q);
    a_ext      = (DW+2)'(acc_q);
    sum        = s1_first_q ? d_ext : a_ext + d_ext;
    clip_hi    = sum > MAXV;
    clip_lo    = sum < MINV;
    clipped    = clip_hi ? MAXV[DW-1:0] : clip_lo ? MINV[DW-1:0] : sum[DW-1:0];
    fcnt_next  = s1_first_q ? 16'd1 : fcnt_q + 16'd1;
    hit_last   = fcnt_next == 16'(FRAME_LEN);
    s1_valid_d = take ? 1'b1 : load ? 1'b0 : s1_valid_q;
    s1_delta_d = take ? in_delta : s1_delta_q;
    s1_first_d = take ? in_first : s1_first_q;
    out_valid_d  = load ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
    out_sample_d = load ? clipped : out_sample_q;
    out_last_d   = load ? hit_last : out_last_q;
    acc_d        = load ? clipped : acc_q;
    fcnt_d       = load ? (hit_last ? 16'd0 : fcnt_next) : fcnt_q;
    sat_d        = (load && (clip_hi || clip_lo)) ? 1'b1 : sat_clr ? 1'b0 : sat_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_delta_q   <= '0;
      s1_first_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      out_last_q   <= 1'b0;
      acc_q        <= '0;
      fcnt_q       <= '0;
      sat_q        <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_delta_q   <= s1_delta_d;
      s1_first_q   <= s1_first_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
      out_last_q   <= out_last_d;
      acc_q        <= acc_d;
      fcnt_q       <= fcnt_d;
      sat_q        <= sat_d;
    end
  end
endmodule
